// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux, fixed or round-robin select, registered output.
// Optional packet lock (channel held until in_last) when STREAM_MUX_PKT_LOCK_EN is defined.
module stream_mux_rr #(
  parameter  int W    = 8,
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] grant
);

  logic [W-1:0]    r_out_data;
  logic            r_out_valid;
  logic [SELW-1:0] r_grant;
  logic [SELW-1:0] r_last;

  logic            w_load_en;
  logic            w_xfer;
  logic            w_fix_ok;
  logic            w_rr_ok;
  logic [SELW-1:0] w_rr_pick;
  logic            w_pick_ok;
  logic [SELW-1:0] w_pick;
  logic [W-1:0]    w_pick_data;
  int              w_d;
  int              w_best_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} state_t;
  state_t          r_state;
  logic [SELW-1:0] r_lock_ch;
  logic            r_out_last;
  logic            w_lock_ok;
  logic            w_pick_last;
`endif

  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin: smallest distance from last+1 (mod N) among valid channels wins.
  always_comb begin
    w_rr_pick = '0;
    w_best_d  = N;
    w_d       = 0;
    w_fix_ok  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_d = (i + N - 1 - int'(r_last)) % N;
      if (in_valid[i] && (w_d < w_best_d)) begin
        w_best_d  = w_d;
        w_rr_pick = SELW'(i);
      end
      if (sel == SELW'(i)) w_fix_ok = in_valid[i];
    end
    w_rr_ok = |in_valid;
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_comb begin
    w_lock_ok = 1'b0;
    for (int i = 0; i < N; i++)
      if (r_lock_ch == SELW'(i)) w_lock_ok = in_valid[i];
  end
`endif

  always_comb begin
    w_pick    = mode ? w_rr_pick : sel;
    w_pick_ok = mode ? w_rr_ok : w_fix_ok;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (r_state == S_LOCKED) begin
      w_pick    = r_lock_ch;
      w_pick_ok = w_lock_ok;
    end
`endif
  end

  // sel values >= N match no channel, so nothing is selected or readied for them.
  always_comb begin
    w_pick_data = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    w_pick_last = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (w_pick == SELW'(i)) begin
        w_pick_data = in_data[i*W +: W];
`ifdef STREAM_MUX_PKT_LOCK_EN
        w_pick_last = in_last[i];
`endif
      end
    end
  end

  assign w_xfer = !reset && w_load_en && w_pick_ok;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = w_xfer && (w_pick == SELW'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant     <= '0;
      r_last      <= SELW'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      r_state     <= S_IDLE;
      r_lock_ch   <= '0;
      r_out_last  <= 1'b0;
`endif
    end else if (w_load_en) begin
      if (w_pick_ok) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pick_data;
        r_grant     <= w_pick;
        if (mode) r_last <= w_pick;
`ifdef STREAM_MUX_PKT_LOCK_EN
        r_out_last <= w_pick_last;
        case (r_state)
          S_IDLE: begin
            if (!w_pick_last) begin
              r_state   <= S_LOCKED;
              r_lock_ch <= w_pick;
            end
          end
          S_LOCKED: begin
            if (w_pick_last) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign grant     = r_grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (N=4 main instance, N=3 select-range instance).
// Queue-free reference model plus directed vectors; packet-lock sequence adapts to STREAM_MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N-1:0] in_last;
  logic         out_last;
  logic         mode;
  logic [1:0]   sel;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   grant;

  logic [3*W-1:0] u3_data;
  logic [2:0]     u3_valid;
  logic [2:0]     u3_ready;
  logic [1:0]     u3_sel;
  logic [W-1:0]   u3_out_data;
  logic           u3_out_valid;
  logic [1:0]     u3_grant;
  logic [2:0]     u3_last;
  logic           u3_out_last;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model state
  bit        m_valid;
  int        m_data;
  int        m_grant;
  int        m_last;
  bit        m_locked;
  int        m_lock_ch;
  bit        m_olast;

  always #5 clk = ~clk;

  stream_mux_rr #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant)
  );

  stream_mux_rr #(.W(W), .N(3)) u3 (
    .clk(clk), .reset(reset), .in_data(u3_data), .in_valid(u3_valid), .in_ready(u3_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(u3_last), .out_last(u3_out_last),
`endif
    .mode(1'b0), .sel(u3_sel), .out_data(u3_out_data), .out_valid(u3_out_valid),
    .out_ready(1'b1), .grant(u3_grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Which channel (if any) the rules allow to transfer right now.
  function automatic void model_pick(output bit ok, output int ch);
    ok = 0;
    ch = 0;
    if (reset || (m_valid && !out_ready)) return;
    if (m_locked) begin
      ch = m_lock_ch;
      ok = in_valid[ch];
    end else if (!mode) begin
      if (int'(sel) < N) begin
        ch = int'(sel);
        ok = in_valid[ch];
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (in_valid[c]) begin
          ok = 1;
          ch = c;
          break;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    bit ok;
    int ch;
    model_pick(ok, ch);
    if (reset) begin
      m_valid = 0; m_data = 0; m_grant = 0; m_last = N - 1;
      m_locked = 0; m_lock_ch = 0; m_olast = 0;
    end else if (!m_valid || out_ready) begin
      if (ok) begin
        m_valid = 1;
        m_data  = int'(in_data[ch*W +: W]);
        m_grant = ch;
        if (mode) m_last = ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_olast = in_last[ch];
        if (!m_locked && !in_last[ch]) begin
          m_locked  = 1;
          m_lock_ch = ch;
        end else if (m_locked && in_last[ch]) begin
          m_locked = 0;
        end
`endif
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ok;
    int ch;
    logic [N-1:0] exp_rdy;
    if (chk_en) begin
      model_pick(ok, ch);
      exp_rdy = '0;
      if (ok) exp_rdy[ch] = 1'b1;
      chk("model_in_ready", in_ready, exp_rdy);
      chk("model_out_valid", out_valid, m_valid);
      chk("model_out_data", out_data, m_data);
      chk("model_grant", grant, m_grant);
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (m_valid) chk("model_out_last", out_last, m_olast);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int TBL = 12;
  bit       t_mode [TBL] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1};
  bit [1:0] t_sel  [TBL] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0};
  bit [3:0] t_vld  [TBL] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b0001, 4'b0011,
                             4'b0011, 4'b0011, 4'b1111, 4'b0100, 4'b1000, 4'b0000};
  bit       t_rdy  [TBL] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef STREAM_MUX_PKT_LOCK_EN
  int pk_exp [4] = '{1, 1, 1, 2};
`else
  int pk_exp [4] = '{1, 2, 0, 1};
`endif

  initial begin
    reset = 1; mode = 0; sel = 0; in_valid = '0; in_data = '0; out_ready = 1; in_last = '1;
    u3_data = 24'h332211; u3_valid = 3'b111; u3_sel = 2'd3; u3_last = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_grant", grant, 0);

    // Fixed select
    reset = 0; chk_en = 1;
    mode = 0; sel = 2; in_valid = 4'b0110; in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
    @(negedge clk);
    chk("fixed_in_ready", in_ready, 4'b0100);
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    chk("fixed_out_data", out_data, 8'hA5);
    chk("fixed_out_valid", out_valid, 1);
    chk("fixed_grant", grant, 2);

    // Round-robin fairness
    @(posedge clk); #1;
    mode = 1; in_valid = 4'b1111; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr_grant", grant, rr_exp[j]);
      chk("rr_out_valid", out_valid, 1);
    end

    // Backpressure: holds ch0's beat, then drain+load on release
    @(posedge clk); #1;
    out_ready = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_grant", grant, 0);
      chk("bp_out_data", out_data, 8'h10);
      @(posedge clk);
    end
    #1;
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_grant", grant, 1);
    chk("bp_release_data", out_data, 8'h11);

    // Boundary: fixed sel to an idle channel; N=3 instance with sel out of range
    @(posedge clk); #1;
    mode = 0; sel = 3; in_valid = 4'b0111;
    @(negedge clk);
    chk("sel_idle_in_ready", in_ready, 0);
    chk("n3_sel3_in_ready", u3_ready, 0);
    chk("n3_sel3_out_valid", u3_out_valid, 0);
    @(posedge clk); #1;
    u3_sel = 2'd1;
    @(negedge clk);
    chk("sel_idle_out_valid", out_valid, 0);
    chk("sel_idle_grant_held", grant, 2);
    chk("sel_idle_data_held", out_data, 8'h12);
    chk("n3_sel1_in_ready", u3_ready, 3'b010);
    @(posedge clk); #1;
    u3_sel = 2'd3;
    chk("n3_sel1_out_data", u3_out_data, 8'h22);
    chk("n3_sel1_grant", u3_grant, 1);
    @(negedge clk);
    chk("n3_sel3_again_in_ready", u3_ready, 0);

    // Mixed vectors checked by the model only
    for (int j = 0; j < TBL; j++) begin
      @(posedge clk); #1;
      mode = t_mode[j]; sel = t_sel[j]; in_valid = t_vld[j]; out_ready = t_rdy[j];
      in_data = {4'd3, 4'(j), 4'd2, 4'(j), 4'd1, 4'(j), 4'd0, 4'(j)};
    end

    // Reset mid-stream
    @(posedge clk); #1;
    mode = 1; in_valid = 4'b1111; out_ready = 1; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(posedge clk); #1;
    chk("pre_reset_out_valid", out_valid, 1);
    reset = 1; out_ready = 0;
    @(negedge clk);
    chk("in_reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_grant", grant, 0);
    reset = 0; out_ready = 1; in_valid = 4'b0001;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 4'b0001);
    @(posedge clk); #1;
    chk("post_reset_first_grant", grant, 0);
    chk("post_reset_first_data", out_data, 8'h10);

    // Packet: ch1 sends 3 beats (last on 3rd) while ch0/ch2 stay valid
    in_valid = 4'b0111; in_last = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk("pkt_grant", grant, pk_exp[j]);
      if (j == 1) in_last = 4'b0010;
      if (j == 2) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
        chk("pkt_out_last", out_last, 1);
`endif
        in_last = 4'b1111;
      end
    end

    @(posedge clk); #1;
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parameterised N-channel, W-bit streaming multiplexer. Successor to the team's fixed 4-channel combinational mux.
- Adds valid/ready handshakes per channel and a registered output stage.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Sits between multiple producer blocks and a single downstream consumer.

Parameters:
- W, 8, data width per channel in bits.
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), width of select and grant fields (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational from state and inputs).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- out_data  output  W  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- grant  output  SELW  index of the channel whose beat is currently held in out_data.

Behaviour:
- Reset values: out_valid = 0, out_data = 0, grant = 0, round-robin pointer last = N-1 (channel 0 wins first).
- Output register state:
  - load_en = !out_valid || out_ready.
  - Output drains when out_valid && out_ready.
  - Drain and load in the same cycle is legal, giving 1 beat/cycle sustained throughput.
  - With out_valid = 1 and out_ready = 0, out_data and grant are held stable and every in_ready = 0.
- Pick logic (combinational):
  - mode = 0: pick = sel; pick_ok = (sel < N) && in_valid[sel]. If sel >= N, no channel is accepted.
  - mode = 1: pick = first i with in_valid[i] set, searching from last+1 upward and wrapping modulo N. pick_ok = |in_valid.
- in_ready[i] = load_en && pick_ok && (i == pick). At most one in_ready bit is high per cycle.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. On a transfer:
  - out_data <= in_data[pick]
  - out_valid <= 1
  - grant <= pick
  - if mode = 1: last <= pick
- Load with no transfer: if load_en && !pick_ok, then out_valid <= 0; out_data and grant hold their previous values.
- Latency: 1 cycle from input transfer to out_valid.
- The round-robin pointer updates only on round-robin transfers. Fixed-mode transfers leave it untouched.
- A mode or sel change applies to the next pick only. A beat already held is never altered or dropped.
- Reset asserted mid-stream discards any held beat (out_valid = 0 on the next edge); no in_ready is asserted during reset.
- Wrap-around: with last = N-1 the search starts at channel 0.

Optional Feature:
- Macro STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds port in_last (input, N bits).
  - Two-state FSM: IDLE / LOCKED.
  - A transfer with in_last[pick] = 0 moves the FSM from IDLE to LOCKED with lock_ch = pick.
  - In LOCKED, pick is forced to lock_ch regardless of mode and sel.
  - A transfer with in_last[lock_ch] = 1 returns the FSM to IDLE and updates last per the mode rules.
  - Adds output out_last (W-independent, 1 bit), registered alongside out_data.
  - Reset returns the FSM to IDLE.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently.

Test Plan:
- Fixed mode (W=8, N=4): mode=0, sel=2, in_valid=4'b0110, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_valid=1, grant=2.
- Round-robin fairness: mode=1, all in_valid=1, out_ready=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; one beat per cycle.
- Backpressure: out_valid=1 and out_ready=0 for 5 cycles -> in_ready=0 throughout; out_data and grant stable; on release, held beat drains and the next beat loads in the same cycle.
- Boundary: mode=0, sel=3 with in_valid[3]=0 -> no transfer, out_valid falls to 0 after the drain; for N=3 with sel=3 -> in_ready stays 0.
- Reset mid-stream: reset=1 while out_valid=1 -> next edge out_valid=0, grant=0; first round-robin pick after reset is channel 0.
- STREAM_MUX_PKT_LOCK_EN: ch1 sends a 3-beat packet (in_last on the 3rd beat) while ch0 and ch2 are valid -> grant = 1,1,1, then 2 (round-robin continues from 1).
